// File: rtl/ep_writeback_shifter_pkg.sv
// Shared types and latency constants for the even-pipe writeback shifter and issue-stage hazard logic.
// Result latencies here must stay consistent with the issue-stage scoreboard.
package ep_writeback_shifter_pkg;

    localparam int DEPTH    = 7;
    localparam int DATA_W   = 128;
    localparam int ADDR_W   = 7;

    localparam int LAT_SF1  = 2;
    localparam int LAT_SF2  = 3;
    localparam int LAT_BYTE = 4;
    localparam int LAT_SP   = 6;
    localparam int LAT_SPI  = 7;

    localparam int ERR_COLLIDE = 0;
    localparam int ERR_ILLEGAL = 1;

    typedef enum logic [2:0] {
        UNIT_SF1  = 3'd0,
        UNIT_SF2  = 3'd1,
        UNIT_BYTE = 3'd2,
        UNIT_SP   = 3'd3,
        UNIT_SPI  = 3'd4
    } ep_unit_t;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] rt_addr;
        logic [DATA_W-1:0] value;
    } ep_stage_t;

    localparam ep_stage_t STAGE_EMPTY = '0;

    // Zero marks an encoding no execution unit produces.
    function automatic int unit_latency(input logic [2:0] unit);
        case (ep_unit_t'(unit))
            UNIT_SF1:  return LAT_SF1;
            UNIT_SF2:  return LAT_SF2;
            UNIT_BYTE: return LAT_BYTE;
            UNIT_SP:   return LAT_SP;
            UNIT_SPI:  return LAT_SPI;
            default:   return 0;
        endcase
    endfunction

endpackage

// File: rtl/ep_writeback_shifter_fwd_lookup.sv
// Priority match of one forwarding address against every in-flight stage.
// The youngest (lowest-numbered) matching valid stage supplies the data.
module ep_fwd_lookup
    import ep_writeback_shifter_pkg::*;
(
    input  ep_stage_t         stages [1:DEPTH],
    input  logic [ADDR_W-1:0] addr,
    output logic              hit,
    output logic [DATA_W-1:0] data
);

    // NOTE: outputs get defaults before the loop so no path leaves them unassigned (no latch).
    always_comb begin
        hit  = 1'b0;
        data = '0;
        // Oldest first, so a younger match overwrites an older one.
        for (int s = DEPTH; s >= 1; s--) begin
            if (stages[s].valid && (stages[s].rt_addr == addr)) begin
                hit  = 1'b1;
                data = stages[s].value;
            end
        end
    end

endmodule

// File: rtl/ep_writeback_shifter.sv
// Even-pipe result shifter: aligns results to the retire stage, writes back, and sources forwarding.
// Define EP_FWD_EN to build the forwarding lookups; otherwise fwd_* outputs are tied to zero.
module ep_writeback_shifter
    import ep_writeback_shifter_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              res_valid,
    input  logic [2:0]        res_unit,
    input  logic [ADDR_W-1:0] res_rt_addr,
    input  logic [DATA_W-1:0] res_value,
    input  logic              flush,
    input  logic [ADDR_W-1:0] fwd_addr_a,
    input  logic [ADDR_W-1:0] fwd_addr_b,
    output logic              fwd_hit_a,
    output logic [DATA_W-1:0] fwd_data_a,
    output logic              fwd_hit_b,
    output logic [DATA_W-1:0] fwd_data_b,
    output logic              wb_en,
    output logic [ADDR_W-1:0] wb_addr,
    output logic [DATA_W-1:0] wb_data,
    output logic [1:0]        err
);

    ep_stage_t  stages      [1:DEPTH];
    ep_stage_t  stages_next [1:DEPTH];
    logic [1:0] err_q;
    logic [1:0] err_next;
    int         ins_lat;
    logic       slot_busy;

    always_comb begin
        stages_next[1] = STAGE_EMPTY;
        for (int s = 2; s <= DEPTH; s++) begin
            stages_next[s] = stages[s-1];
        end
        err_next  = err_q;
        ins_lat   = unit_latency(res_unit);
        slot_busy = 1'b0;

        // The entry about to shift into the insertion slot has priority over the new result.
        for (int s = 2; s <= DEPTH; s++) begin
            if (s == ins_lat) begin
                slot_busy = stages[s-1].valid;
            end
        end

        if (flush) begin
            stages_next = '{default: STAGE_EMPTY};
        end else if (res_valid) begin
            if (ins_lat == 0) begin
                err_next[ERR_ILLEGAL] = 1'b1;
            end else if (slot_busy) begin
                err_next[ERR_COLLIDE] = 1'b1;
            end else begin
                for (int s = 2; s <= DEPTH; s++) begin
                    if (s == ins_lat) begin
                        stages_next[s] = '{valid: 1'b1, rt_addr: res_rt_addr, value: res_value};
                    end
                end
            end
        end
    end

    // NOTE: the whole stage array is reset, not just the valids; wb_addr/wb_data must read 0 in reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stages <= '{default: STAGE_EMPTY};
            err_q  <= '0;
        end else begin
            // NOTE: non-blocking so every stage samples its predecessor's pre-edge value.
            stages <= stages_next;
            err_q  <= err_next;
        end
    end

    assign wb_en   = stages[DEPTH].valid;
    assign wb_addr = stages[DEPTH].rt_addr;
    assign wb_data = stages[DEPTH].value;
    assign err     = err_q;

`ifdef EP_FWD_EN
    ep_fwd_lookup u_fwd_a (
        .stages (stages),
        .addr   (fwd_addr_a),
        .hit    (fwd_hit_a),
        .data   (fwd_data_a)
    );

    ep_fwd_lookup u_fwd_b (
        .stages (stages),
        .addr   (fwd_addr_b),
        .hit    (fwd_hit_b),
        .data   (fwd_data_b)
    );
`else
    logic unused_fwd_addr;
    assign unused_fwd_addr = ^{fwd_addr_a, fwd_addr_b};
    assign fwd_hit_a  = 1'b0;
    assign fwd_data_a = '0;
    assign fwd_hit_b  = 1'b0;
    assign fwd_data_b = '0;
`endif

endmodule

// File: tb/tb_ep_writeback_shifter.sv
// Self-checking bench for ep_writeback_shifter: directed scenarios plus randomized traffic
// against a retire-time scoreboard model.
module tb_ep_writeback_shifter;
    import ep_writeback_shifter_pkg::*;

    logic              clock = 1'b0;
    logic              reset;
    logic              res_valid;
    logic [2:0]        res_unit;
    logic [ADDR_W-1:0] res_rt_addr;
    logic [DATA_W-1:0] res_value;
    logic              flush;
    logic [ADDR_W-1:0] fwd_addr_a;
    logic [ADDR_W-1:0] fwd_addr_b;
    logic              fwd_hit_a;
    logic [DATA_W-1:0] fwd_data_a;
    logic              fwd_hit_b;
    logic [DATA_W-1:0] fwd_data_b;
    logic              wb_en;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic [1:0]        err;

    ep_writeback_shifter dut (
        .clock       (clock),
        .reset       (reset),
        .res_valid   (res_valid),
        .res_unit    (res_unit),
        .res_rt_addr (res_rt_addr),
        .res_value   (res_value),
        .flush       (flush),
        .fwd_addr_a  (fwd_addr_a),
        .fwd_addr_b  (fwd_addr_b),
        .fwd_hit_a   (fwd_hit_a),
        .fwd_data_a  (fwd_data_a),
        .fwd_hit_b   (fwd_hit_b),
        .fwd_data_b  (fwd_data_b),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .err         (err)
    );

    always #5 clock = ~clock;

    typedef struct {
        int                retire;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } flight_t;

    typedef struct {
        int                c;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } wb_rec_t;

    int lat_tab [8] = '{2, 3, 4, 6, 7, 0, 0, 0};

    int                checks   = 0;
    int                failures = 0;
    int                cyc      = 0;
    flight_t           inflight [$];
    wb_rec_t           wb_log   [$];
    logic [1:0]        m_err;
    logic              last_hit_a;
    logic [DATA_W-1:0] last_fwd_a;

    function automatic void model_clear();
        inflight.delete();
        wb_log.delete();
        m_err = 2'b00;
        cyc   = 0;
    endfunction

    // Youngest in-flight match is the one retiring last.
    function automatic void model_fwd(input logic [ADDR_W-1:0] x, output logic hit,
                                      output logic [DATA_W-1:0] data);
        int best;
        best = -1;
        hit  = 1'b0;
        data = '0;
`ifdef EP_FWD_EN
        foreach (inflight[i]) begin
            if (inflight[i].addr == x && inflight[i].retire > best) begin
                best = inflight[i].retire;
                hit  = 1'b1;
                data = inflight[i].data;
            end
        end
`endif
    endfunction

    // Drive one cycle, compare outputs with the scoreboard, then advance the scoreboard.
    task automatic run_cycle(input logic v, input logic [2:0] u, input logic [ADDR_W-1:0] a,
                             input logic [DATA_W-1:0] d, input logic f,
                             input logic [ADDR_W-1:0] fa, input logic [ADDR_W-1:0] fb);
        logic              exp_en, exp_ha, exp_hb, busy;
        logic [ADDR_W-1:0] exp_addr;
        logic [DATA_W-1:0] exp_data, exp_fa, exp_fb;
        int                lat;
        @(negedge clock);
        res_valid   = v;
        res_unit    = u;
        res_rt_addr = a;
        res_value   = d;
        flush       = f;
        fwd_addr_a  = fa;
        fwd_addr_b  = fb;
        #1;
        exp_en   = 1'b0;
        exp_addr = '0;
        exp_data = '0;
        foreach (inflight[i]) begin
            if (inflight[i].retire == cyc) begin
                exp_en   = 1'b1;
                exp_addr = inflight[i].addr;
                exp_data = inflight[i].data;
            end
        end
        model_fwd(fa, exp_ha, exp_fa);
        model_fwd(fb, exp_hb, exp_fb);

        checks++;
        if (wb_en !== exp_en) begin
            failures++;
            $display("FAIL wb_en cyc=%0d got=%b exp=%b", cyc, wb_en, exp_en);
        end
        if (exp_en) begin
            checks++;
            if (wb_addr !== exp_addr || wb_data !== exp_data) begin
                failures++;
                $display("FAIL wb_payload cyc=%0d got=%0d/%h exp=%0d/%h",
                         cyc, wb_addr, wb_data, exp_addr, exp_data);
            end
        end
        checks++;
        if (err !== m_err) begin
            failures++;
            $display("FAIL err cyc=%0d got=%b exp=%b", cyc, err, m_err);
        end
        checks++;
        if (fwd_hit_a !== exp_ha || fwd_data_a !== exp_fa) begin
            failures++;
            $display("FAIL fwd_a cyc=%0d addr=%0d got=%b/%h exp=%b/%h",
                     cyc, fa, fwd_hit_a, fwd_data_a, exp_ha, exp_fa);
        end
        checks++;
        if (fwd_hit_b !== exp_hb || fwd_data_b !== exp_fb) begin
            failures++;
            $display("FAIL fwd_b cyc=%0d addr=%0d got=%b/%h exp=%b/%h",
                     cyc, fb, fwd_hit_b, fwd_data_b, exp_hb, exp_fb);
        end

        last_hit_a = fwd_hit_a;
        last_fwd_a = fwd_data_a;
        if (wb_en === 1'b1) wb_log.push_back('{c: cyc, a: wb_addr, d: wb_data});

        if (f) begin
            inflight.delete();
        end else begin
            for (int i = inflight.size() - 1; i >= 0; i--) begin
                if (inflight[i].retire <= cyc) inflight.delete(i);
            end
            if (v) begin
                lat = lat_tab[u];
                if (lat == 0) begin
                    m_err[1] = 1'b1;
                end else begin
                    busy = 1'b0;
                    foreach (inflight[i]) begin
                        if (DEPTH - (inflight[i].retire - cyc) == lat - 1) busy = 1'b1;
                    end
                    if (busy) m_err[0] = 1'b1;
                    else inflight.push_back('{retire: cyc + 1 + DEPTH - lat, addr: a, data: d});
                end
            end
        end
        cyc++;
    endtask

    task automatic idle(input int n, input logic [ADDR_W-1:0] fa);
        for (int i = 0; i < n; i++) run_cycle(1'b0, 3'd0, '0, '0, 1'b0, fa, fa);
    endtask

    task automatic do_reset();
        reset       = 1'b0;
        res_valid   = 1'b0;
        res_unit    = '0;
        res_rt_addr = '0;
        res_value   = '0;
        flush       = 1'b0;
        fwd_addr_a  = '0;
        fwd_addr_b  = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        model_clear();
    endtask

    task automatic check_wb(input string name, input int idx, input int c,
                            input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        checks++;
        if (idx >= wb_log.size()) begin
            failures++;
            $display("FAIL %s missing writeback #%0d got_count=%0d", name, idx, wb_log.size());
        end else if (wb_log[idx].c != c || wb_log[idx].a !== a || wb_log[idx].d !== d) begin
            failures++;
            $display("FAIL %s wb#%0d got=c%0d/%0d/%0d exp=c%0d/%0d/%0d", name, idx,
                     wb_log[idx].c, wb_log[idx].a, wb_log[idx].d, c, a, d);
        end
    endtask

    task automatic check_count(input string name, input int n, input logic [1:0] exp_err);
        checks++;
        if (wb_log.size() != n || err !== exp_err) begin
            failures++;
            $display("FAIL %s got=%0d wbs err=%b exp=%0d wbs err=%b", name,
                     wb_log.size(), err, n, exp_err);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #2;
        checks++;
        if ({wb_en, wb_addr, wb_data, err, fwd_hit_a, fwd_hit_b} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%b/%0d/%h/%b/%b/%b exp=all zero",
                     wb_en, wb_addr, wb_data, err, fwd_hit_a, fwd_hit_b);
        end
        do_reset();
        idle(3, 7'd0);
    endtask

    task automatic test_sf1_single();
        do_reset();
        run_cycle(1'b1, 3'd0, 7'd5, 128'd30, 1'b0, 7'd5, 7'd0);
        idle(8, 7'd5);
        check_wb("sf1_single", 0, 6, 7'd5, 128'd30);
        check_count("sf1_single_count", 1, 2'b00);
    endtask

    task automatic test_mixed_latency();
        do_reset();
        run_cycle(1'b1, 3'd4, 7'd9, 128'h99, 1'b0, 7'd9, 7'd10);
        run_cycle(1'b1, 3'd0, 7'd10, 128'hA0, 1'b0, 7'd9, 7'd10);
        idle(8, 7'd10);
        check_wb("mixed_spi", 0, 1, 7'd9, 128'h99);
        check_wb("mixed_sf1", 1, 7, 7'd10, 128'hA0);
        check_count("mixed_count", 2, 2'b00);
    endtask

    task automatic test_same_addr();
        logic              exp_h;
        logic [DATA_W-1:0] exp_d;
        do_reset();
        run_cycle(1'b1, 3'd0, 7'd3, 128'd1, 1'b0, 7'd3, 7'd3);
        run_cycle(1'b1, 3'd0, 7'd3, 128'd2, 1'b0, 7'd3, 7'd3);
        run_cycle(1'b0, 3'd0, 7'd0, 128'd0, 1'b0, 7'd3, 7'd3);
`ifdef EP_FWD_EN
        exp_h = 1'b1;
        exp_d = 128'd2;
`else
        exp_h = 1'b0;
        exp_d = 128'd0;
`endif
        checks++;
        if (last_hit_a !== exp_h || last_fwd_a !== exp_d) begin
            failures++;
            $display("FAIL same_addr_fwd got=%b/%0d exp=%b/%0d", last_hit_a, last_fwd_a, exp_h, exp_d);
        end
        idle(7, 7'd3);
        check_wb("same_addr_old", 0, 6, 7'd3, 128'd1);
        check_wb("same_addr_new", 1, 7, 7'd3, 128'd2);
    endtask

    task automatic test_collision();
        do_reset();
        run_cycle(1'b1, 3'd0, 7'd4, 128'd44, 1'b0, 7'd6, 7'd4);
        run_cycle(1'b1, 3'd1, 7'd6, 128'd66, 1'b0, 7'd6, 7'd4);
        idle(8, 7'd6);
        check_wb("collision_keep", 0, 6, 7'd4, 128'd44);
        check_count("collision_count", 1, 2'b01);
        idle(6, 7'd6);
        check_count("collision_sticky", 1, 2'b01);
    endtask

    task automatic test_flush_illegal();
        do_reset();
        run_cycle(1'b1, 3'd2, 7'd8, 128'd88, 1'b0, 7'd8, 7'd8);
        run_cycle(1'b0, 3'd0, 7'd0, 128'd0, 1'b0, 7'd8, 7'd8);
        run_cycle(1'b1, 3'd0, 7'd12, 128'd12, 1'b1, 7'd8, 7'd12);
        run_cycle(1'b0, 3'd0, 7'd0, 128'd0, 1'b0, 7'd8, 7'd12);
        checks++;
        if (last_hit_a !== 1'b0) begin
            failures++;
            $display("FAIL flush_fwd got=%b exp=0", last_hit_a);
        end
        run_cycle(1'b1, 3'd6, 7'd11, 128'd11, 1'b0, 7'd8, 7'd11);
        idle(8, 7'd11);
        check_count("flush_illegal", 0, 2'b10);
    endtask

    task automatic test_random();
        logic [2:0] u;
        do_reset();
        for (int i = 0; i < 250; i++) begin
            u = 3'($urandom_range(0, 4));
            run_cycle(1'($urandom_range(0, 9) < 6), u, 7'($urandom_range(0, 7)),
                      {$urandom, $urandom, $urandom, $urandom}, 1'b0,
                      7'($urandom_range(0, 7)), 7'($urandom_range(0, 7)));
        end
        do_reset();
        for (int i = 0; i < 300; i++) begin
            u = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
            run_cycle(1'($urandom_range(0, 9) < 6), u, 7'($urandom_range(0, 7)),
                      {$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(0, 19) == 0),
                      7'($urandom_range(0, 7)), 7'($urandom_range(0, 7)));
        end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        run_cycle(1'b1, 3'd0, 7'd1, 128'd101, 1'b0, 7'd1, 7'd2);
        run_cycle(1'b1, 3'd0, 7'd2, 128'd102, 1'b0, 7'd1, 7'd2);
        run_cycle(1'b1, 3'd5, 7'd9, 128'd109, 1'b0, 7'd1, 7'd2);
        run_cycle(1'b1, 3'd4, 7'd3, 128'd103, 1'b0, 7'd1, 7'd2);
        run_cycle(1'b0, 3'd0, 7'd0, 128'd0, 1'b0, 7'd1, 7'd2);
        #1;
        reset = 1'b0;
        #1;
        checks++;
        if ({wb_en, wb_addr, wb_data, err, fwd_hit_a, fwd_hit_b} !== '0) begin
            failures++;
            $display("FAIL midstream_reset got=%b/%0d/%h/%b/%b/%b exp=all zero",
                     wb_en, wb_addr, wb_data, err, fwd_hit_a, fwd_hit_b);
        end
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        model_clear();
        idle(10, 7'd1);
        check_count("midstream_no_stale", 0, 2'b00);
    endtask

    initial begin
        test_reset();
        test_sf1_single();
        test_mixed_latency();
        test_same_addr();
        test_collision();
        test_flush_illegal();
        test_random();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
